// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one exec/ready/data_ready memory port between core (C_*) and DMA (D_*).
// Optional feature: define MEM_ARB_RR_EN for round-robin tie-breaking (default is fixed core priority).
module mem_arbiter (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        C_exec,
  input  logic        C_write,
  input  logic [1:0]  C_size,
  input  logic [15:0] C_addr,
  input  logic [15:0] C_data_in,
  output logic        C_ready,
  output logic        C_data_ready,
  output logic [15:0] C_data_out,
  input  logic        D_exec,
  input  logic        D_write,
  input  logic [1:0]  D_size,
  input  logic [15:0] D_addr,
  input  logic [15:0] D_data_in,
  output logic        D_ready,
  output logic        D_data_ready,
  output logic [15:0] D_data_out,
  input  logic        MEM_ready,
  input  logic        MEM_data_ready,
  input  logic [15:0] MEM_data_in,
  output logic        MEM_exec,
  output logic        MEM_write,
  output logic [1:0]  MEM_size,
  output logic [15:0] MEM_addr,
  output logic [15:0] MEM_data_out,
  output logic        O_grant,
  output logic        O_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_c_pending;
  logic        r_d_pending;
  logic        w_c_pending_nxt;
  logic        w_d_pending_nxt;
  logic        w_c_accept;
  logic        w_d_accept;

  logic        r_c_write;
  logic [1:0]  r_c_size;
  logic [15:0] r_c_addr;
  logic [15:0] r_c_data;
  logic        r_d_write;
  logic [1:0]  r_d_size;
  logic [15:0] r_d_addr;
  logic [15:0] r_d_data;

  logic        w_grant_en;
  logic        w_mem_done;
  logic        w_winner;

  logic        r_c_ready;
  logic        r_d_ready;
  logic        r_c_data_ready;
  logic        r_d_data_ready;
  logic [15:0] r_c_data_out;
  logic [15:0] r_d_data_out;
  logic        r_mem_exec;
  logic        r_mem_write;
  logic [1:0]  r_mem_size;
  logic [15:0] r_mem_addr;
  logic [15:0] r_mem_data_out;
  logic        r_grant;
  logic        r_busy;

  // ready is registered as !pending, so it doubles as the accept qualifier
  assign w_c_accept = C_exec & r_c_ready;
  assign w_d_accept = D_exec & r_d_ready;

  always_ff @(posedge I_clk) begin
    if (w_c_accept) begin
      r_c_write <= C_write;
      r_c_size  <= C_size;
      r_c_addr  <= C_addr;
      r_c_data  <= C_data_in;
    end
    if (w_d_accept) begin
      r_d_write <= D_write;
      r_d_size  <= D_size;
      r_d_addr  <= D_addr;
      r_d_data  <= D_data_in;
    end
  end

`ifdef MEM_ARB_RR_EN
  logic r_last_grant;

  always_comb begin
    w_winner = ~r_c_pending;
    if (r_c_pending && r_d_pending) begin
      w_winner = ~r_last_grant;
    end
  end

  // Reset value 1 lets the core win the first tie
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      r_last_grant <= 1'b1;
    end else if (w_grant_en) begin
      r_last_grant <= w_winner;
    end
  end
`else
  assign w_winner = ~r_c_pending;
`endif

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    w_mem_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (MEM_ready && (r_c_pending || r_d_pending)) begin
          w_grant_en  = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (MEM_data_ready) begin
          w_mem_done  = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Set and clear of one pending flag are mutually exclusive: set needs !pending, clear needs pending
  always_comb begin
    w_c_pending_nxt = r_c_pending;
    w_d_pending_nxt = r_d_pending;
    if (w_c_accept) begin
      w_c_pending_nxt = 1'b1;
    end else if (w_mem_done && !r_grant) begin
      w_c_pending_nxt = 1'b0;
    end
    if (w_d_accept) begin
      w_d_pending_nxt = 1'b1;
    end else if (w_mem_done && r_grant) begin
      w_d_pending_nxt = 1'b0;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      r_c_pending <= 1'b0;
      r_d_pending <= 1'b0;
      r_c_ready   <= 1'b1;
      r_d_ready   <= 1'b1;
    end else begin
      r_c_pending <= w_c_pending_nxt;
      r_d_pending <= w_d_pending_nxt;
      r_c_ready   <= ~w_c_pending_nxt;
      r_d_ready   <= ~w_d_pending_nxt;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      r_mem_exec     <= 1'b0;
      r_mem_write    <= 1'b0;
      r_mem_size     <= 2'd0;
      r_mem_addr     <= 16'd0;
      r_mem_data_out <= 16'd0;
      r_grant        <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_mem_exec <= w_grant_en;
      r_busy     <= (w_state_nxt == S_ISSUE) || (w_state_nxt == S_WAIT);
      if (w_grant_en) begin
        r_grant        <= w_winner;
        r_mem_write    <= w_winner ? r_d_write : r_c_write;
        r_mem_size     <= w_winner ? r_d_size  : r_c_size;
        r_mem_addr     <= w_winner ? r_d_addr  : r_c_addr;
        r_mem_data_out <= w_winner ? r_d_data  : r_c_data;
      end
    end
  end

  // Completion is routed to whichever requester holds the grant
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      r_c_data_ready <= 1'b0;
      r_d_data_ready <= 1'b0;
      r_c_data_out   <= 16'd0;
      r_d_data_out   <= 16'd0;
    end else begin
      r_c_data_ready <= w_mem_done & ~r_grant;
      r_d_data_ready <= w_mem_done & r_grant;
      if (w_mem_done && !r_grant) begin
        r_c_data_out <= MEM_data_in;
      end
      if (w_mem_done && r_grant) begin
        r_d_data_out <= MEM_data_in;
      end
    end
  end

  assign C_ready      = r_c_ready;
  assign D_ready      = r_d_ready;
  assign C_data_ready = r_c_data_ready;
  assign D_data_ready = r_d_data_ready;
  assign C_data_out   = r_c_data_out;
  assign D_data_out   = r_d_data_out;
  assign MEM_exec     = r_mem_exec;
  assign MEM_write    = r_mem_write;
  assign MEM_size     = r_mem_size;
  assign MEM_addr     = r_mem_addr;
  assign MEM_data_out = r_mem_data_out;
  assign O_grant      = r_grant;
  assign O_busy       = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table of single transactions, hand-written corner sequences,
// and a randomized run checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  logic        I_clk = 1'b0;
  logic        I_reset;
  logic        C_exec, C_write, C_ready, C_data_ready;
  logic [1:0]  C_size;
  logic [15:0] C_addr, C_data_in, C_data_out;
  logic        D_exec, D_write, D_ready, D_data_ready;
  logic [1:0]  D_size;
  logic [15:0] D_addr, D_data_in, D_data_out;
  logic        MEM_ready, MEM_data_ready, MEM_exec, MEM_write;
  logic [15:0] MEM_data_in, MEM_addr, MEM_data_out;
  logic [1:0]  MEM_size;
  logic        O_grant, O_busy;

  always #5 I_clk = ~I_clk;

  mem_arbiter dut (
    .I_clk(I_clk), .I_reset(I_reset),
    .C_exec(C_exec), .C_write(C_write), .C_size(C_size), .C_addr(C_addr),
    .C_data_in(C_data_in), .C_ready(C_ready), .C_data_ready(C_data_ready), .C_data_out(C_data_out),
    .D_exec(D_exec), .D_write(D_write), .D_size(D_size), .D_addr(D_addr),
    .D_data_in(D_data_in), .D_ready(D_ready), .D_data_ready(D_data_ready), .D_data_out(D_data_out),
    .MEM_ready(MEM_ready), .MEM_data_ready(MEM_data_ready), .MEM_data_in(MEM_data_in),
    .MEM_exec(MEM_exec), .MEM_write(MEM_write), .MEM_size(MEM_size), .MEM_addr(MEM_addr),
    .MEM_data_out(MEM_data_out), .O_grant(O_grant), .O_busy(O_busy)
  );

  typedef struct {
    bit          dma;
    bit          wr;
    logic [1:0]  sz;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    logic [15:0] rdata;
    logic        exp_grant;
    logic [15:0] exp_addr;
    logic        exp_write;
    logic [1:0]  exp_size;
    logic [15:0] exp_mdo;
    logic [15:0] exp_dout;
  } vec_t;

  vec_t tbl[6];

  int vec_n = 0;
  int err_n = 0;
  int cyc   = 0;

  // tb memory responder state and event log
  bit          mem_auto;
  int          mem_lat;
  int          mem_cnt;
  bit          mem_resp_now;
  int          exec_n;
  logic [15:0] exec_addr_q[$];
  logic        exec_grant_q[$];
  int          exec_cyc_q[$];
  int          c_dr_n, d_dr_n;

  // random-phase model
  bit          m_out[2];
  bit          m_iss[2];
  int          m_drv[2];
  int          m_rc[2];
  logic [15:0] m_rd[2];
  logic        m_wr[2];
  logic [1:0]  m_sz[2];
  logic [15:0] m_ad[2];
  logic [15:0] m_dt[2];
  int          m_owner;
  int          m_last;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s @cyc %0d: got %h, required %h", nm, cyc, act, exp);
    end
  endtask

  task automatic cycle();
    @(negedge I_clk);
    cyc++;
    MEM_data_ready = 1'b0;
    mem_resp_now   = 1'b0;
    if (MEM_exec) begin
      exec_n++;
      exec_addr_q.push_back(MEM_addr);
      exec_grant_q.push_back(O_grant);
      exec_cyc_q.push_back(cyc);
    end
    if (C_data_ready) c_dr_n++;
    if (D_data_ready) d_dr_n++;
    if (mem_auto) begin
      if (MEM_exec) begin
        mem_cnt = mem_lat;
      end else if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          MEM_data_ready = 1'b1;
          MEM_data_in    = 16'($urandom);
          mem_resp_now   = 1'b1;
        end
      end
    end
  endtask

  task automatic clr_log();
    exec_n = 0;
    exec_addr_q.delete();
    exec_grant_q.delete();
    exec_cyc_q.delete();
    c_dr_n  = 0;
    d_dr_n  = 0;
    mem_cnt = 0;
  endtask

  task automatic drive_req(input bit dma, input bit wr, input logic [1:0] sz,
                           input logic [15:0] addr, input logic [15:0] data);
    if (dma) begin
      D_exec = 1'b1; D_write = wr; D_size = sz; D_addr = addr; D_data_in = data;
    end else begin
      C_exec = 1'b1; C_write = wr; C_size = sz; C_addr = addr; C_data_in = data;
    end
  endtask

  task automatic apply_reset();
    I_reset = 1'b1;
    C_exec  = 1'b0;
    D_exec  = 1'b0;
    cycle();
    I_reset = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_C_ready"}, 32'(C_ready), 32'(1'b1));
    chk({tag, "_D_ready"}, 32'(D_ready), 32'(1'b1));
    chk({tag, "_C_dr"}, 32'(C_data_ready), 32'(1'b0));
    chk({tag, "_D_dr"}, 32'(D_data_ready), 32'(1'b0));
    chk({tag, "_C_dout"}, 32'(C_data_out), 32'(16'h0));
    chk({tag, "_D_dout"}, 32'(D_data_out), 32'(16'h0));
    chk({tag, "_MEM_exec"}, 32'(MEM_exec), 32'(1'b0));
    chk({tag, "_MEM_write"}, 32'(MEM_write), 32'(1'b0));
    chk({tag, "_MEM_size"}, 32'(MEM_size), 32'(2'd0));
    chk({tag, "_MEM_addr"}, 32'(MEM_addr), 32'(16'h0));
    chk({tag, "_MEM_dout"}, 32'(MEM_data_out), 32'(16'h0));
    chk({tag, "_grant"}, 32'(O_grant), 32'(1'b0));
    chk({tag, "_busy"}, 32'(O_busy), 32'(1'b0));
  endtask

  function automatic logic get_rdy(input bit r);
    return r ? D_ready : C_ready;
  endfunction

  function automatic logic get_dr(input bit r);
    return r ? D_data_ready : C_data_ready;
  endfunction

  function automatic logic [15:0] get_dout(input bit r);
    return r ? D_data_out : C_data_out;
  endfunction

  initial begin
    int k;
    int t0;
    bit rearmed;
    bit c0, c1, exp_dr;
    int w;

    tbl[0] = '{1'b0, 1'b0, 2'd2, 16'h0100, 16'h0000, 1, 16'hBEEF, 1'b0, 16'h0100, 1'b0, 2'd2, 16'h0000, 16'hBEEF};
    tbl[1] = '{1'b1, 1'b1, 2'd1, 16'h2000, 16'h1234, 1, 16'h0000, 1'b1, 16'h2000, 1'b1, 2'd1, 16'h1234, 16'h0000};
    tbl[2] = '{1'b0, 1'b1, 2'd3, 16'h0042, 16'hA5A5, 2, 16'h0F0F, 1'b0, 16'h0042, 1'b1, 2'd3, 16'hA5A5, 16'h0F0F};
    tbl[3] = '{1'b1, 1'b0, 2'd0, 16'hFFFF, 16'h7777, 3, 16'h8001, 1'b1, 16'hFFFF, 1'b0, 2'd0, 16'h7777, 16'h8001};
    tbl[4] = '{1'b0, 1'b0, 2'd1, 16'h8000, 16'h0000, 4, 16'hFFFF, 1'b0, 16'h8000, 1'b0, 2'd1, 16'h0000, 16'hFFFF};
    tbl[5] = '{1'b1, 1'b0, 2'd2, 16'h0000, 16'h0000, 1, 16'h0000, 1'b1, 16'h0000, 1'b0, 2'd2, 16'h0000, 16'h0000};

    C_exec = 1'b0; C_write = 1'b0; C_size = 2'd0; C_addr = 16'h0; C_data_in = 16'h0;
    D_exec = 1'b0; D_write = 1'b0; D_size = 2'd0; D_addr = 16'h0; D_data_in = 16'h0;
    MEM_ready = 1'b1; MEM_data_ready = 1'b0; MEM_data_in = 16'h0;
    mem_auto = 1'b0; mem_lat = 1;
    clr_log();
    I_reset = 1'b1;
    cycle();
    apply_reset();
    chk_reset("reset");

    // Single transactions from the vector table, memory driven by hand
    for (int i = 0; i < 6; i++) begin
      drive_req(tbl[i].dma, tbl[i].wr, tbl[i].sz, tbl[i].addr, tbl[i].wdata);
      t0 = cyc;
      cycle();
      C_exec = 1'b0; D_exec = 1'b0;
      chk("tbl_ready_low", 32'(get_rdy(tbl[i].dma)), 32'(1'b0));
      k = 0;
      while (!MEM_exec && k < 8) begin
        cycle();
        k++;
      end
      chk("tbl_exec", 32'(MEM_exec), 32'(1'b1));
      chk("tbl_exec_latency", 32'(cyc - t0), 32'(2));
      chk("tbl_grant", 32'(O_grant), 32'(tbl[i].exp_grant));
      chk("tbl_addr", 32'(MEM_addr), 32'(tbl[i].exp_addr));
      chk("tbl_write", 32'(MEM_write), 32'(tbl[i].exp_write));
      chk("tbl_size", 32'(MEM_size), 32'(tbl[i].exp_size));
      chk("tbl_mem_dout", 32'(MEM_data_out), 32'(tbl[i].exp_mdo));
      chk("tbl_busy_issue", 32'(O_busy), 32'(1'b1));
      for (int j = 0; j < tbl[i].lat; j++) begin
        cycle();
        chk("tbl_exec_once", 32'(MEM_exec), 32'(1'b0));
        chk("tbl_ready_wait", 32'(get_rdy(tbl[i].dma)), 32'(1'b0));
        chk("tbl_busy_wait", 32'(O_busy), 32'(1'b1));
        chk("tbl_no_early_dr", 32'(get_dr(tbl[i].dma)), 32'(1'b0));
      end
      MEM_data_ready = 1'b1;
      MEM_data_in    = tbl[i].rdata;
      cycle();
      chk("tbl_data_ready", 32'(get_dr(tbl[i].dma)), 32'(1'b1));
      chk("tbl_data_out", 32'(get_dout(tbl[i].dma)), 32'(tbl[i].exp_dout));
      chk("tbl_other_dr", 32'(get_dr(!tbl[i].dma)), 32'(1'b0));
      chk("tbl_ready_back", 32'(get_rdy(tbl[i].dma)), 32'(1'b1));
      chk("tbl_busy_done", 32'(O_busy), 32'(1'b0));
      cycle();
      chk("tbl_dr_pulse", 32'(get_dr(tbl[i].dma)), 32'(1'b0));
    end

    // Simultaneous exec, core re-issues in its DONE cycle to create a second tie
    clr_log();
    mem_auto = 1'b1; mem_lat = 1;
    drive_req(1'b0, 1'b0, 2'd1, 16'h0010, 16'h0);
    drive_req(1'b1, 1'b0, 2'd1, 16'h0020, 16'h0);
    cycle();
    C_exec = 1'b0; D_exec = 1'b0;
    rearmed = 1'b0;
    k = 0;
    while (exec_n < 3 && k < 60) begin
      cycle();
      k++;
      C_exec = 1'b0;
      if (!rearmed && c_dr_n == 1) begin
        drive_req(1'b0, 1'b0, 2'd1, 16'h0030, 16'h0);
        rearmed = 1'b1;
      end
    end
    repeat (8) cycle();
    chk("tie_exec_count", 32'(exec_n), 32'(3));
    chk("tie_dr_counts", 32'(c_dr_n * 16 + d_dr_n), 32'(2 * 16 + 1));
    if (exec_n >= 3) begin
      chk("tie_first_addr", 32'(exec_addr_q[0]), 32'(16'h0010));
      chk("tie_first_grant", 32'(exec_grant_q[0]), 32'(1'b0));
      chk("tie_spacing", 32'(exec_cyc_q[1] - exec_cyc_q[0]), 32'(4));
`ifdef MEM_ARB_RR_EN
      chk("tie_second_addr", 32'(exec_addr_q[1]), 32'(16'h0020));
      chk("tie_second_grant", 32'(exec_grant_q[1]), 32'(1'b1));
      chk("tie_third_addr", 32'(exec_addr_q[2]), 32'(16'h0030));
`else
      chk("tie_second_addr", 32'(exec_addr_q[1]), 32'(16'h0030));
      chk("tie_second_grant", 32'(exec_grant_q[1]), 32'(1'b0));
      chk("tie_third_addr", 32'(exec_addr_q[2]), 32'(16'h0020));
`endif
    end

    // MEM_ready held low while a command is pending
    clr_log();
    mem_lat = 2;
    MEM_ready = 1'b0;
    drive_req(1'b0, 1'b0, 2'd0, 16'h0900, 16'h0);
    cycle();
    C_exec = 1'b0;
    repeat (5) begin
      cycle();
      chk("mr_low_no_exec", 32'(MEM_exec), 32'(1'b0));
    end
    MEM_ready = 1'b1;
    t0 = cyc;
    repeat (12) cycle();
    chk("mr_exec_count", 32'(exec_n), 32'(1));
    chk("mr_exec_cycle", 32'(exec_n > 0 ? exec_cyc_q[0] - t0 : -1), 32'(1));
    chk("mr_done_count", 32'(c_dr_n), 32'(1));

    // C_exec held while C_ready is low must be ignored
    clr_log();
    mem_lat = 3;
    drive_req(1'b0, 1'b0, 2'd2, 16'h0400, 16'h0);
    cycle();
    repeat (4) begin
      drive_req(1'b0, 1'b0, 2'd2, 16'h0500, 16'h0);
      cycle();
    end
    C_exec = 1'b0;
    repeat (12) cycle();
    chk("busy_exec_count", 32'(exec_n), 32'(1));
    chk("busy_exec_addr", 32'(exec_n > 0 ? exec_addr_q[0] : 16'hxxxx), 32'(16'h0400));
    chk("busy_dr_count", 32'(c_dr_n), 32'(1));

    // Reset while in WAIT, then a late memory completion
    clr_log();
    mem_auto = 1'b0;
    drive_req(1'b1, 1'b0, 2'd1, 16'h0700, 16'h0);
    cycle();
    D_exec = 1'b0;
    k = 0;
    while (!MEM_exec && k < 8) begin
      cycle();
      k++;
    end
    chk("rst_wait_exec", 32'(MEM_exec), 32'(1'b1));
    cycle();
    apply_reset();
    chk_reset("rst_wait");
    cycle();
    MEM_data_ready = 1'b1;
    MEM_data_in    = 16'hDEAD;
    repeat (4) begin
      cycle();
      chk("late_C_dr", 32'(C_data_ready), 32'(1'b0));
      chk("late_D_dr", 32'(D_data_ready), 32'(1'b0));
      chk("late_D_dout", 32'(D_data_out), 32'(16'h0));
      chk("late_exec", 32'(MEM_exec), 32'(1'b0));
    end

    // Randomized traffic against the transaction-level model
    apply_reset();
    clr_log();
    mem_auto = 1'b1;
    m_last = 1;
    m_owner = 0;
    for (int r = 0; r < 2; r++) begin
      m_out[r] = 1'b0; m_iss[r] = 1'b0; m_drv[r] = 0; m_rc[r] = -1;
    end
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if (MEM_exec) begin
        // a request is eligible if it was latched at or before the grant edge
        c0 = m_out[0] && !m_iss[0] && (m_drv[0] <= cyc - 2);
        c1 = m_out[1] && !m_iss[1] && (m_drv[1] <= cyc - 2);
        if (!c0 && !c1) begin
          vec_n++; err_n++;
          $display("FAIL rnd_unexpected_exec @cyc %0d: got MEM_exec=1, required no eligible request -> 0", cyc);
        end else begin
          if (c0 && c1) begin
`ifdef MEM_ARB_RR_EN
            w = (m_last == 1) ? 0 : 1;
`else
            w = 0;
`endif
          end else begin
            w = c0 ? 0 : 1;
          end
          chk("rnd_grant", 32'(O_grant), 32'(w));
          chk("rnd_addr", 32'(MEM_addr), 32'(m_ad[w]));
          chk("rnd_write", 32'(MEM_write), 32'(m_wr[w]));
          chk("rnd_size", 32'(MEM_size), 32'(m_sz[w]));
          chk("rnd_mem_dout", 32'(MEM_data_out), 32'(m_dt[w]));
          chk("rnd_mem_ready_at_grant", 32'(MEM_ready), 32'(1'b1));
          m_iss[w] = 1'b1;
          m_owner = w;
          m_last = w;
        end
      end
      if (mem_resp_now) begin
        m_rc[m_owner] = cyc;
        m_rd[m_owner] = MEM_data_in;
      end
      for (int r = 0; r < 2; r++) begin
        exp_dr = m_out[r] && (m_rc[r] == cyc - 1);
        chk("rnd_data_ready", 32'(get_dr(r[0])), 32'(exp_dr));
        if (exp_dr) begin
          chk("rnd_data_out", 32'(get_dout(r[0])), 32'(m_rd[r]));
          m_out[r] = 1'b0; m_iss[r] = 1'b0; m_rc[r] = -1;
        end
        chk("rnd_ready", 32'(get_rdy(r[0])), 32'(!m_out[r]));
        if (m_out[r] && (cyc - m_drv[r] > 400)) begin
          vec_n++; err_n++;
          $display("FAIL rnd_timeout @cyc %0d: requester %0d waited %0d cycles, required completion", cyc, r, cyc - m_drv[r]);
          m_out[r] = 1'b0; m_iss[r] = 1'b0; m_rc[r] = -1;
        end
      end
      C_exec = 1'b0;
      D_exec = 1'b0;
      if (i < 2940) begin
        for (int r = 0; r < 2; r++) begin
          if ($urandom_range(0, 99) < 35) begin
            logic        nwr;
            logic [1:0]  nsz;
            logic [15:0] nad, ndt;
            nwr = 1'($urandom_range(0, 1));
            nsz = 2'($urandom_range(0, 3));
            nad = 16'($urandom);
            ndt = 16'($urandom);
            drive_req(r[0], nwr, nsz, nad, ndt);
            if (!m_out[r]) begin
              m_out[r] = 1'b1; m_drv[r] = cyc;
              m_wr[r] = nwr; m_sz[r] = nsz; m_ad[r] = nad; m_dt[r] = ndt;
            end
          end
        end
      end
      MEM_ready = ($urandom_range(0, 3) != 0);
      mem_lat   = $urandom_range(1, 4);
      if (mem_cnt == 0 && !mem_resp_now && $urandom_range(0, 7) == 0) begin
        MEM_data_ready = 1'b1;
        MEM_data_in    = 16'($urandom);
      end
    end
    chk("rnd_drain_C", 32'(m_out[0]), 32'(1'b0));
    chk("rnd_drain_D", 32'(m_out[1]), 32'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single external memory port between the CPU core's memory interface and a DMA engine. It sits between both requesters and the memory device. It accepts one command per requester, serialises them onto the MEM_* bus and routes each completion back to its originator. Each requester sees the same exec/ready/data_ready protocol the memory presents.

## Interface
- No parameters; all widths fixed (16-bit address/data, 2-bit size).
- I_clk  in  1  clock; reset I_reset, synchronous, active-high.
- I_reset  in  1  synchronous active-high reset.
- C_exec, D_exec  in  1  command strobe from core / DMA (sampled only while own ready high).
- C_write, D_write  in  1  1 = write, 0 = read.
- C_size, D_size  in  2  transfer size code, passed through unchanged.
- C_addr, D_addr  in  16  address.
- C_data_in, D_data_in  in  16  write data.
- C_ready, D_ready  out  1  arbiter can accept a command from this requester.
- C_data_ready, D_data_ready  out  1  one-cycle completion pulse.
- C_data_out, D_data_out  out  16  read data, valid while the matching data_ready pulse is high.
- MEM_ready  in  1  memory idle and accepting.
- MEM_data_ready  in  1  one-cycle completion pulse from memory, for reads and writes.
- MEM_data_in  in  16  read data from memory.
- MEM_exec  out  1  one-cycle command strobe to memory.
- MEM_write, MEM_size, MEM_addr, MEM_data_out  out  1/2/16/16  latched command of the granted requester.
- O_grant  out  1  0 = core owns the bus, 1 = DMA; holds its last value when idle.
- O_busy  out  1  high in ISSUE and WAIT.

## Operation
- Each requester has a command latch (write, size, addr, data) and a pending flag. Rules:
  - C_ready = !C_pending and D_ready = !D_pending, both registered.
  - exec && ready sets pending and captures the command at that edge.
  - exec while ready is low is ignored.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: if MEM_ready and any pending, select a winner, load O_grant and the MEM_* command registers, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: MEM_exec = 1 for exactly this cycle, then go to WAIT unconditionally.
  - WAIT: hold the MEM_* outputs. On MEM_data_ready, register MEM_data_in into the granted requester's data_out, clear its pending flag, and go to DONE.
  - DONE: the granted requester's data_ready = 1 for this cycle, then go to IDLE.
- Selection defaults to fixed priority: core wins whenever C_pending. See Configuration.
- MEM_data_ready outside WAIT is ignored.
- Simultaneous exec from both requesters in the same cycle: both are latched and served back to back.
- A requester may issue its next exec in the DONE cycle. It is latched and considered in the following IDLE.
- Reset outputs: MEM_exec=0, MEM_write=0, MEM_size=0, MEM_addr=0, MEM_data_out=0, C/D_data_ready=0, C/D_data_out=0, C/D_ready=1, O_grant=0, O_busy=0. State is IDLE and pending flags are cleared.
- Reset mid-transaction abandons the request. A late MEM_data_ready arriving afterwards is ignored because the FSM is in IDLE.

## Timing
- exec sampled at edge E0 → pending in cycle 1 → IDLE grants at edge E1 (if MEM_ready) → MEM_exec high in cycle 2.
- MEM_data_ready in cycle M → data_ready pulse and data_out valid in cycle M+1 → ready high again in cycle M+1.
- Minimum turnaround: back-to-back grants are separated by DONE plus IDLE, i.e. MEM_exec pulses are at least 4 cycles apart for a memory that responds in 1 cycle.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - A last_grant register is updated on each grant.
  - When both requesters are pending, the one not granted last wins.
  - last_grant resets to 1, so the core wins the first tie.
- MEM_ARB_RR_EN undefined: fixed priority, core always wins a tie, and DMA may starve. No last_grant register exists.

## Test plan
- Single core read:
  - Stimulus: C_exec with addr 0x0100, size 2; memory returns 0xBEEF one cycle after MEM_exec.
  - Required: MEM_exec pulse carries MEM_addr=0x0100; C_data_ready pulse with C_data_out=0xBEEF; D_data_ready stays 0.
- DMA write:
  - Stimulus: D_exec with write=1, addr 0x2000, data 0x1234.
  - Required: MEM_write=1, MEM_data_out=0x1234, O_grant=1; D_ready low until the cycle after MEM_data_ready.
- Simultaneous exec, core to 0x0010 and DMA to 0x0020:
  - Required: core served first, then DMA, with two MEM_exec pulses in that order.
  - With MEM_ARB_RR_EN, repeating the tie immediately serves DMA first on the second round.
- MEM_ready held low for 5 cycles with a command pending:
  - Required: no MEM_exec until MEM_ready rises, then exactly one pulse.
- Reset asserted in WAIT:
  - Required: all outputs return to their reset values.
  - A MEM_data_ready pulse two cycles after reset produces no requester data_ready.
- C_exec while C_ready is low (during an outstanding core read):
  - Required: ignored, with exactly one MEM_exec and one C_data_ready issued.
